// File: rtl/intc_pkg.sv
// Shared definitions for the intc_ctrl interrupt controller: register offsets,
// FSM state encoding and register bit positions.
package intc_pkg;

    localparam logic [1:0] INTC_PEND = 2'd0;
    localparam logic [1:0] INTC_EN   = 2'd1;
    localparam logic [1:0] INTC_VEC  = 2'd2;
    localparam logic [1:0] INTC_CMD  = 2'd3;

    localparam int VEC_ACT       = 15;
    localparam int CMD_EOI       = 0;
    localparam int CMD_SWSET_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SRV  = 2'd2
    } intc_state_e;

endpackage

// File: rtl/intc_prio_enc.sv
// Lowest-index-wins priority encoder over the enabled pending vector.
module intc_prio_enc #(
    parameter int N_SRC = 4,
    parameter int SRC_W = 3
) (
    input  logic [N_SRC-1:0] req_i,
    output logic             any_o,
    output logic [SRC_W-1:0] id_o
);

    // Scan upward; only the first set bit latches its index.
    always_comb begin
        any_o = 1'b0;
        id_o  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_o  = (req_i[i] && !any_o) ? SRC_W'(i) : id_o;
            any_o = any_o | req_i[i];
        end
    end

endmodule

// File: rtl/intc_ctrl.sv
// Memory-mapped interrupt controller: edge capture, enable mask, fixed priority,
// vector readback and EOI sequencing. Optional input synchronizer: INTC_SYNC_EN.
module intc_ctrl
    import intc_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [1:0]       addr,
    input  logic             we,
    input  logic [15:0]      din,
    output logic [15:0]      dout,
    input  logic [N_SRC-1:0] intp_ext,
    output logic             int_vld,
    input  logic             int_rdy
);

    logic [N_SRC-1:0] samp_s, edge_s, w1c_s, swset_s, ackclr_s;
    logic [N_SRC-1:0] prev_q, pend_q, pend_d, en_q, en_d;
    logic [SRC_W-1:0] vec_id_q, vec_id_d, id_s;
    logic             vec_act_q, vec_act_d, vld_q, vld_d;
    logic             any_s, eoi_s, ack_s;
    logic             unused_din_s;
    intc_state_e      state_q, state_d;

    assign unused_din_s = ^din;

`ifdef INTC_SYNC_EN
    logic [N_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous interrupt lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= intp_ext;
            sync2_q <= sync1_q;
        end
    end
    assign samp_s = sync2_q;
`else
    assign samp_s = intp_ext;
`endif

    intc_prio_enc #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_prio (
        .req_i (pend_q & en_q),
        .any_o (any_s),
        .id_o  (id_s)
    );

    // Bus writes and pending update; any set source beats both clear sources.
    always_comb begin
        edge_s   = samp_s & ~prev_q;
        w1c_s    = '0;
        swset_s  = '0;
        eoi_s    = 1'b0;
        en_d     = en_q;
        ackclr_s = ack_s ? (N_SRC'(1'b1) << id_s) : '0;
        if (sel && we) begin
            case (addr)
                INTC_PEND: w1c_s = din[N_SRC-1:0];
                INTC_EN:   en_d  = din[N_SRC-1:0];
                INTC_CMD: begin
                    eoi_s   = din[CMD_EOI];
                    swset_s = din[CMD_SWSET_LSB +: N_SRC];
                end
                default:   w1c_s = '0;
            endcase
        end else begin
            en_d = en_q;
        end
        pend_d = (pend_q & ~w1c_s & ~ackclr_s) | edge_s | swset_s;
    end

    // Request/service sequencing; int_vld is the registered REQ indication.
    always_comb begin
        state_d   = state_q;
        vld_d     = 1'b0;
        ack_s     = 1'b0;
        vec_act_d = vec_act_q;
        vec_id_d  = vec_id_q;
        case (state_q)
            IDLE: begin
                if (any_s) begin
                    state_d = REQ;
                    vld_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (int_rdy && any_s) begin
                    ack_s     = 1'b1;
                    state_d   = SRV;
                    vec_act_d = 1'b1;
                    vec_id_d  = id_s;
                end else if (!any_s) begin
                    state_d = IDLE;
                end else begin
                    vld_d = 1'b1;
                end
            end
            SRV: begin
                if (eoi_s) begin
                    state_d   = IDLE;
                    vec_act_d = 1'b0;
                    vec_id_d  = '0;
                end else begin
                    state_d = SRV;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and register storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            prev_q    <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            vec_act_q <= 1'b0;
            vec_id_q  <= '0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= samp_s;
            pend_q    <= pend_d;
            en_q      <= en_d;
            vec_act_q <= vec_act_d;
            vec_id_q  <= vec_id_d;
            vld_q     <= vld_d;
        end
    end

    assign int_vld = vld_q;

    // Read mux; unused bits and deselected reads return zero.
    always_comb begin
        dout = 16'h0000;
        if (sel) begin
            case (addr)
                INTC_PEND: dout[N_SRC-1:0] = pend_q;
                INTC_EN:   dout[N_SRC-1:0] = en_q;
                INTC_VEC: begin
                    dout[VEC_ACT]   = vec_act_q;
                    dout[SRC_W-1:0] = vec_id_q;
                end
                default:   dout = 16'h0000;
            endcase
        end else begin
            dout = 16'h0000;
        end
    end

endmodule

// File: tb/tb_intc_ctrl.sv
// Scoreboard bench for intc_ctrl: stimulus queues expected register/int_vld
// values, a negedge monitor pops and compares them.
module tb_intc_ctrl;

`ifdef INTC_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic [3:0]  intp_ext = 4'h0;
    logic        int_vld;
    logic        int_rdy = 1'b0;

    typedef struct {
        string       name;
        bit          is_vld;
        logic [15:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [15:0] mon_act;
    logic        chk = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    intc_ctrl #(.N_SRC(4), .SRC_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .addr     (addr),
        .we       (we),
        .din      (din),
        .dout     (dout),
        .intp_ext (intp_ext),
        .int_vld  (int_vld),
        .int_rdy  (int_rdy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk) begin
            while (sb_q.size() > 0) begin
                mon_e   = sb_q.pop_front();
                mon_act = mon_e.is_vld ? {15'd0, int_vld} : dout;
                n_checks++;
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%04h, want 0x%04h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (SYNC_LAT) tick();
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        tick();
        sel = 1'b0; we = 1'b0; din = 16'h0000;
    endtask

    task automatic ack();
        int_rdy = 1'b1;
        tick();
        int_rdy = 1'b0;
    endtask

    // One probe: register read plus int_vld, sampled at negedge, costs one clock edge.
    task automatic check(input string nm, input logic [1:0] a, input logic [15:0] er, input logic ev);
        sb_q.push_back('{nm, 1'b0, er});
        sb_q.push_back('{{nm, "_vld"}, 1'b1, {15'd0, ev}});
        sel = 1'b1; we = 1'b0; addr = a;
        chk = 1'b1;
        @(negedge clk);
        #1;
        chk = 1'b0; sel = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        check("rst_pend", 2'd0, 16'h0000, 1'b0);
        check("rst_en",   2'd1, 16'h0000, 1'b0);
        check("rst_vec",  2'd2, 16'h0000, 1'b0);
        rst = 1'b0;
        tick();

        // single source request/ack/EOI
        bus_wr(2'd1, 16'h000F);
        intp_ext = 4'h4; tick(); intp_ext = 4'h0; settle();
        check("t1_pend",    2'd0, 16'h0004, 1'b0);
        check("t1_req",     2'd0, 16'h0004, 1'b1);
        ack();
        check("t1_vec",     2'd2, 16'h8002, 1'b0);
        check("t1_pendclr", 2'd0, 16'h0000, 1'b0);
        bus_wr(2'd3, 16'h0001);
        check("t1_eoi",     2'd2, 16'h0000, 1'b0);
        check("t1_idle",    2'd2, 16'h0000, 1'b0);

        // simultaneous sources, lowest index first
        intp_ext = 4'hA; tick(); intp_ext = 4'h0; settle();
        check("t2_pend",    2'd0, 16'h000A, 1'b0);
        check("t2_req",     2'd2, 16'h0000, 1'b1);
        ack();
        check("t2_vec1",    2'd2, 16'h8001, 1'b0);
        check("t2_pend3",   2'd0, 16'h0008, 1'b0);
        bus_wr(2'd3, 16'h0001);
        check("t2_eoi",     2'd2, 16'h0000, 1'b0);
        check("t2_rereq",   2'd0, 16'h0008, 1'b1);
        ack();
        check("t2_vec3",    2'd2, 16'h8003, 1'b0);
        bus_wr(2'd3, 16'h0001);
        check("t2_eoi2",    2'd0, 16'h0000, 1'b0);

        // request withdrawn by disabling the source
        bus_wr(2'd1, 16'h0001);
        intp_ext = 4'h1; tick(); intp_ext = 4'h0; settle();
        check("t3_pend",    2'd0, 16'h0001, 1'b0);
        check("t3_req",     2'd0, 16'h0001, 1'b1);
        bus_wr(2'd1, 16'h0000);
        check("t3_hold",    2'd0, 16'h0001, 1'b1);
        check("t3_drop",    2'd1, 16'h0000, 1'b0);
        check("t3_keep",    2'd0, 16'h0001, 1'b0);
        bus_wr(2'd1, 16'h0001);
        check("t3_en",      2'd1, 16'h0001, 1'b0);
        check("t3_back",    2'd2, 16'h0000, 1'b1);
        ack();
        check("t3_vec",     2'd2, 16'h8000, 1'b0);
        bus_wr(2'd3, 16'h0001);
        check("t3_eoi",     2'd2, 16'h0000, 1'b0);

        // set beats W1C, software set, upper bits ignored
        intp_ext = 4'h4; settle();
        bus_wr(2'd0, 16'h0004);
        intp_ext = 4'h0;
        check("t4_setwins", 2'd0, 16'h0004, 1'b0);
        bus_wr(2'd3, 16'h0200);
        check("t4_swset",   2'd0, 16'h0006, 1'b0);
        bus_wr(2'd0, 16'h0006);
        check("t4_w1c",     2'd0, 16'h0000, 1'b0);
        bus_wr(2'd1, 16'hFFFF);
        check("t4_enmask",  2'd1, 16'h000F, 1'b0);
        check("t4_cmdrd",   2'd3, 16'h0000, 1'b0);

        // reset during service with a held input
        intp_ext = 4'h1; tick(); settle();
        check("t5_pend",    2'd0, 16'h0001, 1'b0);
        check("t5_req",     2'd0, 16'h0001, 1'b1);
        ack();
        check("t5_srv",     2'd2, 16'h8000, 1'b0);
        rst = 1'b1;
        check("t5_rst_vec", 2'd2, 16'h0000, 1'b0);
        check("t5_rst_en",  2'd1, 16'h0000, 1'b0);
        rst = 1'b0;
        tick(); settle();
        check("t5_edge",    2'd0, 16'h0001, 1'b0);
        check("t5_noreq",   2'd0, 16'h0001, 1'b0);
        bus_wr(2'd0, 16'h0001);
        check("t5_oneedge", 2'd0, 16'h0000, 1'b0);
        intp_ext = 4'h0;
        tick();

        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d leftover, want 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
